aish_zone_scanner: RTL
======================

Name: aish_zone_scanner

Overview:
- Sequencer on the controlling side of the 16:1 sensor-select multiplexer.
- Drives the 4-bit select, waits for the mux output to settle, samples the selected sensor bit, and debounces each of the 16 zones across scans.
- Publishes a 16-bit zone status word and a latched, acknowledgeable alarm for the armed zones.
- Sits between the sensor mux and the alarm/annunciator logic of the security system.

Parameters:
- DWELL, 2: settle cycles after each select change before sampling. Legal range 1..15.
- DEBOUNCE, 2: consecutive disagreeing samples of a zone needed to flip its status. Legal range 1..7.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- enable  input  1  high = scan continuously.
- mux_in  input  1  selected sensor bit returned by the mux.
- arm_mask  input  16  1 = zone is armed and can raise the alarm.
- ack  input  1  one-cycle alarm acknowledge.
- sel  output  4  mux select, registered.
- zone_status  output  16  debounced sensor state per zone.
- alarm  output  1  latched alarm.
- alarm_zone  output  4  lowest-index armed active zone at the time of the latch.
- scan_done  output  1  one-cycle pulse at the end of each full 16-zone scan.

Behaviour:
- Reset (rst high at a clk edge) forces all of the following, regardless of state or mid-scan position:
  - sel = 0, zone_status = 0, alarm = 0, alarm_zone = 0, scan_done = 0.
  - all debounce counters = 0, settle counter = 0, FSM = IDLE.
- FSM states: IDLE, SETTLE, SAMPLE.
  - IDLE: sel held at 0. If enable = 1, go to SETTLE and load settle count = DWELL.
  - SETTLE: decrement the settle count each cycle; go to SAMPLE when it reaches 0. SETTLE lasts DWELL cycles.
  - SAMPLE: lasts one cycle. Captures mux_in for zone sel and updates that zone's debounce counter.
    - If sel < 15: increment sel, reload DWELL, go to SETTLE.
    - If sel = 15: wrap sel to 0 and pulse scan_done in the next cycle. Then go to SETTLE if enable = 1, otherwise go to IDLE.
- Timing:
  - Each zone takes DWELL+1 cycles; a full scan takes 16*(DWELL+1) cycles (48 at the defaults).
  - sel changes only on the edge that leaves SAMPLE.
- enable:
  - Sampled only in IDLE and on the SAMPLE cycle of zone 15.
  - Deasserting it mid-scan completes the current scan, then returns to IDLE.
- Debounce, per zone i, using a 3-bit counter c[i], evaluated at the SAMPLE edge of zone i:
  - If sample == zone_status[i]: c[i] = 0.
  - Else if c[i]+1 == DEBOUNCE: toggle zone_status[i] and set c[i] = 0.
  - Else: c[i] = c[i]+1.
- Alarm path, registered one cycle behind zone_status:
  - trip = |(zone_status & arm_mask).
  - If alarm = 0 and trip = 1: set alarm = 1 and load alarm_zone with the lowest set bit index of (zone_status & arm_mask).
  - While alarm = 1, alarm_zone holds even if further zones trip.
  - If alarm = 1, ack = 1 and trip = 0: clear alarm; alarm_zone holds its last value.
  - If ack = 1 while trip = 1: ack is ignored and alarm stays 1 (trip wins over ack).
  - Changing arm_mask takes effect the next cycle.
- No combinational path from any input to any output.

Test Plan:
- Reset/idle:
  - Stimulus: rst high 2 cycles, enable = 0 for 100 cycles.
  - Required: sel = 0, zone_status = 0, alarm = 0, scan_done never pulses.
- Scan timing (defaults):
  - Stimulus: enable = 1, mux_in = 0.
  - Required: sel steps 0,1,…,15, each value held 3 cycles.
  - Required: scan_done pulses every 48 cycles; sel wraps to 0.
- Debounce:
  - Stimulus: bench models the mux with zone 5 input = 1, all others 0; arm_mask = 0.
  - Required: zone_status[5] = 0 after scan 1; it becomes 1 at the zone-5 SAMPLE edge of scan 2; alarm stays 0.
  - Stimulus: a single-scan glitch to 1 on zone 9.
  - Required: zone_status[9] never changes.
- Alarm latch and priority:
  - Stimulus: arm_mask = 16'h0220, zones 5 and 9 both held at 1.
  - Required: alarm = 1 one cycle after zone_status[5] sets, with alarm_zone = 5.
  - Required: alarm_zone stays 5 after zone 9 also sets.
- Acknowledge:
  - Stimulus: ack while zone 5 is still active.
  - Required: alarm stays 1.
  - Stimulus: release zones 5 and 9 so that two scans later zone_status = 0, then pulse ack.
  - Required: alarm = 0 the next cycle.
- Enable drop and reset mid-scan:
  - Stimulus: deassert enable while sel = 7.
  - Required: scan continues to sel = 15, scan_done pulses, FSM enters IDLE with sel = 0.
  - Stimulus: assert rst while sel = 10 and alarm = 1.
  - Required: all outputs return to 0 on the next edge.

Source files
------------

// File: rtl/aish_zone_scanner.sv
`default_nettype none
// ============================================================================
// Module      : aish_zone_scanner
// Description : Drives a 16:1 sensor mux, debounces every zone across scans
//               and latches an acknowledgeable alarm for armed zones.
// Revision    : 1.0 - initial release
// ============================================================================
module aish_zone_scanner #(
  parameter int DWELL    = 2,
  parameter int DEBOUNCE = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        mux_in,
  input  logic [15:0] arm_mask,
  input  logic        ack,
  output logic [3:0]  sel,
  output logic [15:0] zone_status,
  output logic        alarm,
  output logic [3:0]  alarm_zone,
  output logic        scan_done
);

  localparam logic [3:0] DWELL_LD = 4'(DWELL);
  localparam logic [2:0] DEB_TGT  = 3'(DEBOUNCE);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [3:0]  settle_cnt, settle_next;
  logic [3:0]  sel_next;
  logic        done_next;
  logic [15:0] armed;
  logic [3:0]  low_idx;
  logic        trip;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      settle_cnt <= 4'd0;
      sel        <= 4'd0;
      scan_done  <= 1'b0;
    end else begin
      state      <= state_next;
      settle_cnt <= settle_next;
      sel        <= sel_next;
      scan_done  <= done_next;
    end
  end

  // enable is only looked at in IDLE and on the last zone's sample cycle,
  // so a mid-scan drop always finishes the scan in progress.
  always_comb begin
    state_next  = state;
    settle_next = settle_cnt;
    sel_next    = sel;
    done_next   = 1'b0;
    case (state)
      IDLE: begin
        sel_next = 4'd0;
        if (enable) begin
          state_next  = SETTLE;
          settle_next = DWELL_LD;
        end
      end
      SETTLE: begin
        settle_next = settle_cnt - 4'd1;
        if (settle_cnt <= 4'd1) state_next = SAMPLE;
      end
      SAMPLE: begin
        if (sel != 4'd15) begin
          sel_next    = sel + 4'd1;
          settle_next = DWELL_LD;
          state_next  = SETTLE;
        end else begin
          sel_next  = 4'd0;
          done_next = 1'b1;
          if (enable) begin
            state_next  = SETTLE;
            settle_next = DWELL_LD;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  for (genvar i = 0; i < 16; i++) begin : g_zone
    logic       hit;
    logic       st;
    logic [2:0] cnt;

    assign hit = (state == SAMPLE) && (sel == 4'(i));

    always_ff @(posedge clk) begin
      if (rst) begin
        st  <= 1'b0;
        cnt <= 3'd0;
      end else if (hit) begin
        if (mux_in == st) begin
          cnt <= 3'd0;
        end else if (3'(cnt + 3'd1) == DEB_TGT) begin
          st  <= ~st;
          cnt <= 3'd0;
        end else begin
          cnt <= cnt + 3'd1;
        end
      end
    end

    assign zone_status[i] = st;
  end

  // Descending scan so the last hit written is the lowest active index.
  always_comb begin
    armed   = zone_status & arm_mask;
    low_idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (armed[i]) low_idx = 4'(i);
    end
  end

  assign trip = |armed;

  // An active trip always beats ack, so the alarm cannot be cleared early.
  always_ff @(posedge clk) begin
    if (rst) begin
      alarm      <= 1'b0;
      alarm_zone <= 4'd0;
    end else if (!alarm && trip) begin
      alarm      <= 1'b1;
      alarm_zone <= low_idx;
    end else if (alarm && ack && !trip) begin
      alarm <= 1'b0;
    end
  end

endmodule
`default_nettype wire
